// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock frequency monitor.
// The window counter is sized from the window length by a helper function.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam int DEF_WIN_LEN = 256;
    localparam int DEF_CNT_W   = 9;
    localparam int DEF_LOCK_N  = 4;

    function automatic int win_cnt_width(input int win_len);
        return (win_len > 1) ? $clog2(win_len) : 1;
    endfunction

endpackage

// File: rtl/clk_mon_edge_sync.sv
// Two-flop synchroniser followed by a delay flop and a rising-edge detector.
// Suitable for any slow asynchronous status input sampled in sys_clk.
module clk_mon_edge_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic async_sig,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic dly_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            dly_reg  <= 1'b0;
        end else begin
            meta_reg <= async_sig;
            sync_reg <= meta_reg;
            dly_reg  <= sync_reg;
        end
    end

    assign rise = sync_reg & ~dly_reg;

endmodule

// File: rtl/clk_mon.sv
// Clock frequency monitor: counts mon_clk rising edges over fixed sys_clk
// windows, checks each count against a band and tracks lock status.
module clk_mon #(
    parameter int WIN_LEN = clk_mon_pkg::DEF_WIN_LEN,
    parameter int CNT_W   = clk_mon_pkg::DEF_CNT_W,
    parameter int LOCK_N  = clk_mon_pkg::DEF_LOCK_N
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic [CNT_W-1:0] lo_bound,
    input  logic [CNT_W-1:0] hi_bound,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_vld,
    output logic             in_range,
    output logic             locked,
    output logic             lost
);

    import clk_mon_pkg::*;

    localparam int WIN_W  = win_cnt_width(WIN_LEN);
    localparam int GOOD_W = $clog2(LOCK_N + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);

    state_t state_reg;
    state_t state_next;

    logic [WIN_W-1:0]  win_cnt_reg;
    logic [CNT_W-1:0]  edge_cnt_reg;
    logic [CNT_W-1:0]  meas_cnt_reg;
    logic              meas_vld_reg;
    logic              in_range_reg;
    logic              locked_reg;
    logic              lost_arm_reg;
    logic              lost_reg;
    logic [GOOD_W-1:0] good_cnt_reg;

    logic              rise;
    logic [CNT_W-1:0]  edge_total;
    logic              win_end;
    logic              abort;
    logic              range_ok;
    logic [GOOD_W-1:0] good_inc;

    clk_mon_edge_sync u_edge_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .async_sig (mon_clk),
        .rise      (rise)
    );

    // Window total including an edge arriving in the final MEAS cycle.
    assign edge_total = (rise && (edge_cnt_reg != CNT_MAX)) ? edge_cnt_reg + 1'b1
                                                            : edge_cnt_reg;

    assign win_end  = (state_reg == MEAS) && enable && (win_cnt_reg == WIN_LAST);
    assign abort    = (state_reg == MEAS) && !enable;
    assign range_ok = (edge_total >= lo_bound) && (edge_total <= hi_bound);
    assign good_inc = (good_cnt_reg == GOOD_MAX) ? GOOD_MAX : good_cnt_reg + 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (enable) state_next = MEAS;
            MEAS: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (win_cnt_reg == WIN_LAST) begin
                    state_next = EVAL;
                end
            end
            EVAL:    state_next = enable ? MEAS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters only run while staying in MEAS, so EVAL sees them cleared
    // and any edge landing in EVAL is discarded.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
        end else if ((state_reg == MEAS) && (state_next == MEAS)) begin
            win_cnt_reg  <= win_cnt_reg + 1'b1;
            edge_cnt_reg <= edge_total;
        end else begin
            win_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
        end
    end

    // Results load on the MEAS->EVAL edge so meas_vld, in_range and locked
    // are all visible during the EVAL cycle; lost follows one cycle later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meas_cnt_reg <= '0;
            meas_vld_reg <= 1'b0;
            in_range_reg <= 1'b0;
            locked_reg   <= 1'b0;
            lost_arm_reg <= 1'b0;
            lost_reg     <= 1'b0;
            good_cnt_reg <= '0;
        end else begin
            meas_vld_reg <= win_end;
            lost_arm_reg <= win_end && !range_ok && locked_reg;
            lost_reg     <= lost_arm_reg;
            if (win_end) begin
                meas_cnt_reg <= edge_total;
                in_range_reg <= range_ok;
                if (range_ok) begin
                    good_cnt_reg <= good_inc;
                    locked_reg   <= (good_inc == GOOD_MAX);
                end else begin
                    good_cnt_reg <= '0;
                    locked_reg   <= 1'b0;
                end
            end else if (abort) begin
                good_cnt_reg <= '0;
                locked_reg   <= 1'b0;
            end
        end
    end

    assign meas_cnt = meas_cnt_reg;
    assign meas_vld = meas_vld_reg;
    assign in_range = in_range_reg;
    assign locked   = locked_reg;
    assign lost     = lost_reg;

endmodule

// File: tb/tb_clk_mon.sv
// Directed bench for clk_mon: lock, loss, stuck input, enable abort,
// mid-window reset and inverted bounds.
module tb_clk_mon;

    localparam int WIN_LEN = 256;
    localparam int CNT_W   = 9;
    localparam int LOCK_N  = 4;
    localparam int PERIOD  = WIN_LEN + 1;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             mon_clk;
    logic             enable;
    logic [CNT_W-1:0] lo_bound;
    logic [CNT_W-1:0] hi_bound;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_vld;
    logic             in_range;
    logic             locked;
    logic             lost;

    int checks   = 0;
    int failures = 0;
    int mon_half = 20;

    clk_mon #(
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W),
        .LOCK_N  (LOCK_N)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mon_clk   (mon_clk),
        .enable    (enable),
        .lo_bound  (lo_bound),
        .hi_bound  (hi_bound),
        .meas_cnt  (meas_cnt),
        .meas_vld  (meas_vld),
        .in_range  (in_range),
        .locked    (locked),
        .lost      (lost)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // mon_half=20 gives sys_clk/4, 40 gives sys_clk/8, 0 holds mon_clk low.
    initial begin
        mon_clk = 1'b0;
        #2;
        forever begin
            if (mon_half == 0) begin
                mon_clk = 1'b0;
                #10;
            end else begin
                #(mon_half) mon_clk = ~mon_clk;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns the number of rising sys_clk edges until meas_vld, or -1.
    task automatic wait_vld(output int n);
        n = -1;
        for (int i = 1; i <= 4 * PERIOD && n < 0; i++) begin
            @(posedge sys_clk);
            #1;
            if (meas_vld === 1'b1) n = i;
        end
        $display("window: cycles=%0d meas_cnt=%0d in_range=%0b locked=%0b", n, meas_cnt, in_range, locked);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        enable    = 1'b0;
        lo_bound  = 9'd60;
        hi_bound  = 9'd68;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({meas_cnt, meas_vld, in_range, locked, lost} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got cnt=%0d vld=%0b rng=%0b lk=%0b lost=%0b want all 0",
                     meas_cnt, meas_vld, in_range, locked, lost);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        checks++;
        if ({meas_cnt, meas_vld, in_range, locked, lost} !== 13'd0) begin
            failures++;
            $display("FAIL reset_release_idle: got cnt=%0d vld=%0b rng=%0b lk=%0b lost=%0b want all 0",
                     meas_cnt, meas_vld, in_range, locked, lost);
        end
    endtask

    task automatic test_lock();
        int n;
        int total;
        logic exp_lk;
        total = 0;
        @(negedge sys_clk);
        enable = 1'b1;
        for (int w = 1; w <= LOCK_N; w++) begin
            wait_vld(n);
            total += n;
            exp_lk = (w == LOCK_N);
            checks++;
            if (n !== PERIOD) begin
                failures++;
                $display("FAIL lock_period w%0d: got %0d want %0d", w, n, PERIOD);
            end
            checks++;
            if (meas_cnt !== 9'd64) begin
                failures++;
                $display("FAIL lock_cnt w%0d: got %0d want 64", w, meas_cnt);
            end
            checks++;
            if (in_range !== 1'b1) begin
                failures++;
                $display("FAIL lock_in_range w%0d: got %0b want 1", w, in_range);
            end
            checks++;
            if (locked !== exp_lk) begin
                failures++;
                $display("FAIL lock_locked w%0d: got %0b want %0b", w, locked, exp_lk);
            end
        end
        checks++;
        if (total !== 4 * PERIOD) begin
            failures++;
            $display("FAIL lock_total_cycles: got %0d want %0d", total, 4 * PERIOD);
        end
    endtask

    task automatic test_lost();
        int n;
        mon_half = 40;
        wait_vld(n);
        checks++;
        if ({in_range, locked, lost} !== 3'b000) begin
            failures++;
            $display("FAIL lost_eval: got rng=%0b lk=%0b lost=%0b want 0 0 0", in_range, locked, lost);
        end
        @(posedge sys_clk);
        #1;
        checks++;
        if (lost !== 1'b1) begin
            failures++;
            $display("FAIL lost_pulse: got %0b want 1", lost);
        end
        @(posedge sys_clk);
        #1;
        checks++;
        if (lost !== 1'b0) begin
            failures++;
            $display("FAIL lost_one_cycle: got %0b want 0", lost);
        end
        wait_vld(n);
        checks++;
        if (n !== PERIOD - 2) begin
            failures++;
            $display("FAIL lost_next_period: got %0d want %0d", n, PERIOD - 2);
        end
        checks++;
        if ({meas_cnt, in_range, locked} !== {9'd32, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL div8_window: got cnt=%0d rng=%0b lk=%0b want 32 0 0", meas_cnt, in_range, locked);
        end
    endtask

    task automatic test_hold_low();
        int n;
        mon_half = 0;
        wait_vld(n);
        wait_vld(n);
        checks++;
        if ({meas_cnt, in_range} !== {9'd0, 1'b0}) begin
            failures++;
            $display("FAIL hold_low_cnt: got cnt=%0d rng=%0b want 0 0", meas_cnt, in_range);
        end
        lo_bound = 9'd0;
        wait_vld(n);
        checks++;
        if ({meas_cnt, in_range, locked} !== {9'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL hold_low_lo0: got cnt=%0d rng=%0b lk=%0b want 0 1 0", meas_cnt, in_range, locked);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        int seen;
        lo_bound = 9'd60;
        mon_half = 20;
        for (int w = 0; w < 8 && locked !== 1'b1; w++) wait_vld(n);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL drop_relock: got %0b want 1", locked);
        end
        // EVAL cycle now; after 101 edges win_cnt reads 100.
        repeat (101) @(posedge sys_clk);
        #1;
        enable = 1'b0;
        @(posedge sys_clk);
        #1;
        checks++;
        if ({meas_vld, locked, lost} !== 3'b000) begin
            failures++;
            $display("FAIL drop_abort: got vld=%0b lk=%0b lost=%0b want 0 0 0", meas_vld, locked, lost);
        end
        seen = 0;
        repeat (300) begin
            @(posedge sys_clk);
            #1;
            if (meas_vld === 1'b1 || lost === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL drop_quiet: got %0d pulses want 0", seen);
        end
        enable = 1'b1;
        wait_vld(n);
        checks++;
        if (n !== PERIOD) begin
            failures++;
            $display("FAIL drop_reenable_period: got %0d want %0d", n, PERIOD);
        end
        checks++;
        if ({meas_cnt, in_range, locked} !== {9'd64, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL drop_reenable_window: got cnt=%0d rng=%0b lk=%0b want 64 1 0", meas_cnt, in_range, locked);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int w = 0; w < 8 && locked !== 1'b1; w++) wait_vld(n);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_relock: got %0b want 1", locked);
        end
        repeat (50) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({meas_cnt, meas_vld, in_range, locked, lost} !== 13'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got cnt=%0d vld=%0b rng=%0b lk=%0b lost=%0b want all 0",
                     meas_cnt, meas_vld, in_range, locked, lost);
        end
        repeat (3) @(posedge sys_clk);
        // Release while mon_clk is low so the synchroniser sees no false edge.
        @(negedge mon_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_vld(n);
        checks++;
        if (n !== PERIOD) begin
            failures++;
            $display("FAIL rstmid_period: got %0d want %0d", n, PERIOD);
        end
        checks++;
        if ({meas_cnt, in_range, locked} !== {9'd64, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_window: got cnt=%0d rng=%0b lk=%0b want 64 1 0", meas_cnt, in_range, locked);
        end
    endtask

    task automatic test_swapped_bounds();
        int n;
        lo_bound = 9'd70;
        hi_bound = 9'd60;
        for (int w = 1; w <= 5; w++) begin
            wait_vld(n);
            checks++;
            if ({meas_cnt, in_range, locked} !== {9'd64, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL swapped w%0d: got cnt=%0d rng=%0b lk=%0b want 64 0 0", w, meas_cnt, in_range, locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_lost();
        test_hold_low();
        test_enable_drop();
        test_reset_mid();
        test_swapped_bounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
